// File: rtl/dbus_wb_if_pkg.sv
// Shared definitions for the data-side Wishbone bus interface: FSM encodings,
// pipeline stall-vector layout and the common enable/zero constants.
package dbus_wb_if_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'b00,
    ST_BUSY       = 2'b01,
    ST_WAIT_STALL = 2'b10
  } state_e;

  // Position of the memory-access stage in the pipeline stall vector.
  localparam int STALL_MEM = 4;

  localparam logic        CHIP_ENABLE  = 1'b1;
  localparam logic        WRITE_ENABLE = 1'b1;
  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;

endpackage

// File: rtl/dbus_wb_if.sv
// Runs one memory-access-stage request as a single-beat Wishbone classic cycle,
// stalls the pipeline until it completes, and aborts cycles the slave never acks.
module dbus_wb_if
  import dbus_wb_if_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall_i,
  input  logic        flush_i,
  input  logic        cpu_ce_i,
  input  logic        cpu_we_i,
  input  logic [3:0]  cpu_sel_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_data_i,
  output logic [31:0] cpu_data_o,
  output logic        stallreq_o,
  output logic        bus_err_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic        wb_ack_i
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [31:0]        rd_buf_q;

  logic start;      // IDLE accepts a request this cycle
  logic bus_end;    // BUSY terminates this cycle (flush, ack or timeout)
  logic ack_ok;     // termination is a genuine acknowledge
  logic abort;      // termination is a timeout
  logic buf_clr;    // flush while holding completed data

  // Only the memory-access stage's stall bit matters here.
  logic unused_stall;
  assign unused_stall = ^{stall_i[5], stall_i[3:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    state_d    = state_q;
    stallreq_o = 1'b0;
    cpu_data_o = ZERO_WORD;
    start      = 1'b0;
    bus_end    = 1'b0;
    ack_ok     = 1'b0;
    abort      = 1'b0;
    buf_clr    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        stallreq_o = cpu_ce_i & ~flush_i;
        if (cpu_ce_i == CHIP_ENABLE && !flush_i) begin
          start   = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (flush_i) begin
          // Flush wins over a simultaneous ack; the ack data is dropped.
          bus_end = 1'b1;
          state_d = ST_IDLE;
        end else if (wb_ack_i) begin
          bus_end = 1'b1;
          ack_ok  = 1'b1;
          if (wb_we_o != WRITE_ENABLE) cpu_data_o = wb_dat_i;
          state_d = stall_i[STALL_MEM] ? ST_WAIT_STALL : ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          bus_end = 1'b1;
          abort   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          stallreq_o = 1'b1;
        end
      end
      ST_WAIT_STALL: begin
        cpu_data_o = rd_buf_q;
        if (flush_i) begin
          buf_clr = 1'b1;
          state_d = ST_IDLE;
        end else if (!stall_i[STALL_MEM]) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_adr_o  <= ZERO_WORD;
      wb_dat_o  <= ZERO_WORD;
      wb_we_o   <= 1'b0;
      wb_sel_o  <= 4'b0000;
      wb_stb_o  <= 1'b0;
      wb_cyc_o  <= 1'b0;
      bus_err_o <= 1'b0;
      cnt_q     <= '0;
      rd_buf_q  <= ZERO_WORD;
    end else begin
      bus_err_o <= abort;
      if (start) begin
        wb_adr_o <= cpu_addr_i;
        wb_dat_o <= cpu_data_i;
        wb_we_o  <= cpu_we_i;
        wb_sel_o <= cpu_sel_i;
        wb_stb_o <= 1'b1;
        wb_cyc_o <= 1'b1;
        cnt_q    <= '0;
      end else if (bus_end) begin
        wb_adr_o <= ZERO_WORD;
        wb_dat_o <= ZERO_WORD;
        wb_we_o  <= 1'b0;
        wb_sel_o <= 4'b0000;
        wb_stb_o <= 1'b0;
        wb_cyc_o <= 1'b0;
        rd_buf_q <= (ack_ok && wb_we_o != WRITE_ENABLE) ? wb_dat_i : ZERO_WORD;
      end else if (state_q == ST_BUSY) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (buf_clr) rd_buf_q <= ZERO_WORD;
    end
  end

endmodule
